// File: rtl/axi_rw_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rw_arbiter
//   Shares the core's single AXI4 master port between the instruction-fetch
//   requester (IF, read only) and the memory-stage requester (MEM, read or
//   write). One single-beat transaction is in flight at a time; the granted
//   requester receives a one-cycle done pulse (plus read data for reads).
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   if_req/if_addr           IF read request (level, held until if_done)
//   if_rdata/if_done         IF read data, valid with the if_done pulse
//   mem_rreq/mem_wreq        MEM read / write request (level, held until mem_done)
//   mem_addr/mem_wdata/
//   mem_wstrb                MEM address, write data, byte strobes
//   mem_rdata/mem_done       MEM read data, valid with the mem_done pulse
//   resp_err                 pulses with a done pulse when rresp/bresp != OKAY
//   stallreq_for_cache       pipeline hold while any request is outstanding
//   ar*/r*/aw*/w*/b*         AXI4 master channels (single beat, INCR burst)
// -----------------------------------------------------------------------------
module axi_rw_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4,
   parameter int IF_ID  = 0,
   parameter int MEM_ID = 1
) (
   input  logic                clk,
   input  logic                rst,
   // IF requester
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_done,
   // MEM requester
   input  logic                mem_rreq,
   input  logic                mem_wreq,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W/8-1:0] mem_wstrb,
   output logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_done,
   // status
   output logic                resp_err,
   output logic                stallreq_for_cache,
   // AXI AR
   output logic                arvalid,
   input  logic                arready,
   output logic [ADDR_W-1:0]   araddr,
   output logic [ID_W-1:0]     arid,
   output logic [7:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   // AXI R
   input  logic                rvalid,
   output logic                rready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic [ID_W-1:0]     rid,
   // AXI AW
   output logic                awvalid,
   input  logic                awready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [ID_W-1:0]     awid,
   output logic [7:0]          awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   // AXI W
   output logic                wvalid,
   input  logic                wready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   // AXI B
   input  logic                bvalid,
   output logic                bready,
   input  logic [1:0]          bresp,
   input  logic [ID_W-1:0]     bid
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AR   = 3'd1;
   localparam logic [2:0] S_R    = 3'd2;
   localparam logic [2:0] S_AW_W = 3'd3;
   localparam logic [2:0] S_B    = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [2:0]      AXI_SIZE   = 3'($clog2(DATA_W/8));
   localparam logic [1:0]      BURST_INCR = 2'b01;
   localparam logic [ID_W-1:0] IF_ID_V    = ID_W'(IF_ID);
   localparam logic [ID_W-1:0] MEM_ID_V   = ID_W'(MEM_ID);

   logic [2:0]          state, state_nxt;
   logic                owner_mem;     // 1: MEM owns the transaction, 0: IF
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wstrb_q;
   logic                err_q;
   logic                aw_acc, w_acc; // channel already handshaken in AW_W
   logic [DATA_W-1:0]   if_rdata_q, mem_rdata_q;

   logic mem_any;
   logic aw_ok, w_ok;

   assign mem_any = mem_rreq | mem_wreq;
   // A channel counts as finished if it was accepted earlier or is being accepted now.
   assign aw_ok   = aw_acc | awready;
   assign w_ok    = w_acc  | wready;

   // ---------------------------------------------------------------- next state
   always_comb begin
      // NOTE: default assignment first so no path through the case leaves
      // state_nxt unassigned and infers a latch.
      state_nxt = state;
      case (state)
         S_IDLE: begin
            // MEM is the older instruction: it must never wait behind fetch.
            if (mem_wreq)                 state_nxt = S_AW_W;
            else if (mem_rreq || if_req)  state_nxt = S_AR;
         end
         S_AR:   if (arready)            state_nxt = S_R;
         S_R:    if (rvalid && rlast)    state_nxt = S_DONE;
         S_AW_W: if (aw_ok && w_ok)      state_nxt = S_B;
         S_B:    if (bvalid)             state_nxt = S_DONE;
         S_DONE:                         state_nxt = S_IDLE;
         default:                        state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the latched address/data and read-data registers are reset as
         // well, because their values are visible on the ports right after reset.
         state       <= S_IDLE;
         owner_mem   <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         err_q       <= 1'b0;
         aw_acc      <= 1'b0;
         w_acc       <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // is computed from pre-edge values regardless of statement order.
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (mem_any || if_req) begin
                  owner_mem <= mem_any;
                  addr_q    <= mem_any ? mem_addr : if_addr;
                  wdata_q   <= mem_wdata;
                  wstrb_q   <= mem_wstrb;
                  err_q     <= 1'b0;
                  aw_acc    <= 1'b0;
                  w_acc     <= 1'b0;
               end
            end
            S_R: begin
               if (rvalid && rlast) begin
                  if (owner_mem) mem_rdata_q <= rdata;
                  else           if_rdata_q  <= rdata;
                  err_q <= |rresp;
               end
            end
            S_AW_W: begin
               if (awready) aw_acc <= 1'b1;
               if (wready)  w_acc  <= 1'b1;
            end
            S_B: begin
               if (bvalid) err_q <= |bresp;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   // Valids decode from registered state, so they and their latched payload
   // cannot change until the handshake moves the FSM on.
   assign arvalid = (state == S_AR);
   assign araddr  = addr_q;
   assign arid    = owner_mem ? MEM_ID_V : IF_ID_V;
   assign arlen   = 8'd0;
   assign arsize  = AXI_SIZE;
   assign arburst = BURST_INCR;

   assign rready  = (state == S_R);

   assign awvalid = (state == S_AW_W) && !aw_acc;
   assign awaddr  = addr_q;
   assign awid    = MEM_ID_V;
   assign awlen   = 8'd0;
   assign awsize  = AXI_SIZE;
   assign awburst = BURST_INCR;

   assign wvalid  = (state == S_AW_W) && !w_acc;
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wlast   = 1'b1;

   assign bready  = (state == S_B);

   assign if_done   = (state == S_DONE) && !owner_mem;
   assign mem_done  = (state == S_DONE) &&  owner_mem;
   assign resp_err  = (state == S_DONE) &&  err_q;
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;

   // The done cycle releases the stall so the pipeline advances with the data.
   assign stallreq_for_cache = (if_req | mem_any) && (state != S_DONE);

   // Only one transaction is ever outstanding, so response IDs carry no information.
   logic unused_ids;
   assign unused_ids = ^{rid, bid};

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rw_arbiter
//   Directed bench for axi_rw_arbiter with a reactive AXI slave whose per-channel
//   wait counts are set by the stimulus. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_axi_rw_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int ID_W   = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                if_req;
   logic [ADDR_W-1:0]   if_addr;
   logic [DATA_W-1:0]   if_rdata;
   logic                if_done;
   logic                mem_rreq, mem_wreq;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W/8-1:0] mem_wstrb;
   logic [DATA_W-1:0]   mem_rdata;
   logic                mem_done;
   logic                resp_err;
   logic                stallreq_for_cache;
   logic                arvalid, arready;
   logic [ADDR_W-1:0]   araddr;
   logic [ID_W-1:0]     arid;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                rvalid, rready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic [ID_W-1:0]     rid;
   logic                awvalid, awready;
   logic [ADDR_W-1:0]   awaddr;
   logic [ID_W-1:0]     awid;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                wvalid, wready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                bvalid, bready;
   logic [1:0]          bresp;
   logic [ID_W-1:0]     bid;

   always #5 clk = ~clk;

   axi_rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .IF_ID(0), .MEM_ID(1)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .mem_rreq(mem_rreq), .mem_wreq(mem_wreq), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_done(mem_done),
      .resp_err(resp_err), .stallreq_for_cache(stallreq_for_cache),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
      .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
      .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
   );

   // ---------------------------------------------------------------- slave model
   int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
   int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
   logic r_pend, aw_got, w_got, b_pend;
   logic aw_hs, w_hs;

   assign arready = arvalid && (ar_cnt >= ar_wait);
   assign rvalid  = r_pend  && (r_cnt  >= r_wait);
   assign rlast   = rvalid;
   assign rid     = '0;
   assign awready = awvalid && (aw_cnt >= aw_wait);
   assign wready  = wvalid  && (w_cnt  >= w_wait);
   assign bvalid  = b_pend  && (b_cnt  >= b_wait);
   assign bid     = '0;
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;

   always @(posedge clk) begin
      if (rst) begin
         ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
         r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
      end else begin
         ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
         aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (wvalid  && !wready)  ? w_cnt  + 1 : 0;
         if (arvalid && arready) begin
            r_pend <= 1'b1; r_cnt <= 0;
         end else if (rvalid && rready) begin
            r_pend <= 1'b0;
         end else if (r_pend && !rvalid) begin
            r_cnt <= r_cnt + 1;
         end
         if ((aw_hs || w_hs) && (aw_got || aw_hs) && (w_got || w_hs)) begin
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
         end else begin
            if (aw_hs) aw_got <= 1'b1;
            if (w_hs)  w_got  <= 1'b1;
            if (bvalid && bready)     b_pend <= 1'b0;
            else if (b_pend && !bvalid) b_cnt <= b_cnt + 1;
         end
      end
   end

   // ---------------------------------------------------------------- monitors
   // Valid/payload stability while a handshake is pending, done-pulse counts.
   int stable_viol = 0, both_done = 0, mem_done_cnt = 0, if_done_cnt = 0;
   logic ar_hold = 1'b0, aw_hold = 1'b0, w_hold = 1'b0;
   logic [ADDR_W-1:0] ar_addr_p, aw_addr_p;
   logic [DATA_W-1:0] w_data_p;
   logic [DATA_W/8-1:0] w_strb_p;

   always @(posedge clk) begin
      if (rst) begin
         ar_hold <= 1'b0; aw_hold <= 1'b0; w_hold <= 1'b0;
      end else begin
         if ((ar_hold && (!arvalid || araddr !== ar_addr_p)) ||
             (aw_hold && (!awvalid || awaddr !== aw_addr_p)) ||
             (w_hold  && (!wvalid || wdata !== w_data_p || wstrb !== w_strb_p)))
            stable_viol <= stable_viol + 1;
         if (if_done && mem_done) both_done <= both_done + 1;
         if (mem_done) mem_done_cnt <= mem_done_cnt + 1;
         if (if_done)  if_done_cnt  <= if_done_cnt + 1;
         ar_hold <= arvalid && !arready;  ar_addr_p <= araddr;
         aw_hold <= awvalid && !awready;  aw_addr_p <= awaddr;
         w_hold  <= wvalid  && !wready;   w_data_p  <= wdata;  w_strb_p <= wstrb;
      end
   end

   // ---------------------------------------------------------------- checking
   int n_cmp = 0, n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Counts falling edges until a done pulse is seen (bounded at 100).
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(if_done || mem_done) && n < 100);
   endtask

   int n, base;

   initial begin
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      mem_rreq = 1'b0; mem_wreq = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
      rdata = '0; rresp = 2'b00; bresp = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_outputs", {arvalid, awvalid, wvalid, rready, bready, if_done, mem_done,
                            resp_err, stallreq_for_cache}, 0);
      check("rst_rdata", {if_rdata[31:0], mem_rdata[31:0]}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_quiet", {arvalid, awvalid, wvalid, rready, bready}, 0);
      check("const_fields", {arlen, awlen, arsize, awsize, arburst, awburst, wlast},
            {8'd0, 8'd0, 3'd3, 3'd3, 2'b01, 2'b01, 1'b1});

      // --- 1: zero-wait IF read, step by step
      if_addr = 32'h8000_0000; rdata = 64'h0000_0013_0000_0093; if_req = 1'b1;
      @(negedge clk);
      check("t1_ar", {arvalid, rready, stallreq_for_cache}, 3'b101);
      check("t1_araddr", araddr, 32'h8000_0000);
      check("t1_arid", arid, 0);
      @(negedge clk);
      check("t1_r", {arvalid, rready, stallreq_for_cache, if_done}, 4'b0110);
      @(negedge clk);
      check("t1_done", {if_done, mem_done, resp_err, stallreq_for_cache}, 4'b1000);
      check("t1_rdata", if_rdata, 64'h0000_0013_0000_0093);
      if_req = 1'b0;
      @(negedge clk);
      check("t1_after", {if_done, rready, arvalid}, 0);

      // --- 2: IF and MEM read together, MEM first
      if_addr = 32'h0000_0200; mem_addr = 32'h0000_0100; rdata = 64'hAAAA_0000_1111_2222;
      if_req = 1'b1; mem_rreq = 1'b1;
      @(negedge clk);
      check("t2_mem_arid", arid, 1);
      check("t2_mem_araddr", araddr, 32'h0000_0100);
      wait_done(n);
      check("t2_mem_lat", n, 2);
      check("t2_mem_done", {mem_done, if_done}, 2'b10);
      check("t2_mem_rdata", mem_rdata, 64'hAAAA_0000_1111_2222);
      mem_rreq = 1'b0; rdata = 64'hBBBB_3333_4444_5555;
      @(negedge clk);
      check("t2_idle_gap", {arvalid, if_done, mem_done}, 0);
      @(negedge clk);
      check("t2_if_ar", {arvalid, arid}, {1'b1, 4'd0});
      check("t2_if_araddr", araddr, 32'h0000_0200);
      wait_done(n);
      check("t2_if_lat", n, 2);
      check("t2_if_done", {if_done, mem_done}, 2'b10);
      check("t2_if_rdata", if_rdata, 64'hBBBB_3333_4444_5555);
      check("t2_mem_hold", mem_rdata, 64'hAAAA_0000_1111_2222);
      if_req = 1'b0;
      @(negedge clk);

      // --- 3: write, AW accepted 3 cycles before W
      w_wait = 3;
      mem_addr = 32'h8000_1000; mem_wdata = 64'hDEAD_BEEF_0000_0001; mem_wstrb = 8'h0F;
      mem_wreq = 1'b1;
      @(negedge clk);
      check("t3_aw_w", {awvalid, wvalid, awready, wready, arvalid}, 5'b11100);
      check("t3_awaddr", awaddr, 32'h8000_1000);
      check("t3_wdata", wdata, 64'hDEAD_BEEF_0000_0001);
      check("t3_wstrb_id", {wstrb, awid, wlast}, {8'h0F, 4'd1, 1'b1});
      @(negedge clk);
      check("t3_aw_dropped", {awvalid, wvalid}, 2'b01);
      wait_done(n);
      check("t3_lat", n, 4);
      check("t3_done", {mem_done, if_done, resp_err}, 3'b100);
      mem_wreq = 1'b0; w_wait = 0;
      @(negedge clk);

      // --- 4: slow slave on AR and R
      ar_wait = 5; r_wait = 4; base = mem_done_cnt;
      mem_addr = 32'h0000_4000; rdata = 64'h0123_4567_89AB_CDEF; mem_rreq = 1'b1;
      wait_done(n);
      check("t4_lat", n, 12);
      check("t4_rdata", mem_rdata, 64'h0123_4567_89AB_CDEF);
      mem_rreq = 1'b0; ar_wait = 0; r_wait = 0;
      repeat (2) @(negedge clk);
      check("t4_done_once", mem_done_cnt - base, 1);
      check("t4_stable", stable_viol, 0);

      // --- 5: write with SLVERR
      bresp = 2'b10; mem_addr = 32'h0000_0008; mem_wstrb = 8'hFF; mem_wreq = 1'b1;
      wait_done(n);
      check("t5_lat", n, 3);
      check("t5_err", {mem_done, resp_err}, 2'b11);
      mem_wreq = 1'b0; bresp = 2'b00;
      @(negedge clk);
      check("t5_err_pulse", {mem_done, resp_err}, 2'b00);

      // --- 6: reset while in R, then a fresh fetch
      r_wait = 10; if_addr = 32'h0000_0300; if_req = 1'b1;
      repeat (3) @(negedge clk);
      check("t6_in_r", rready, 1);
      rst = 1'b1; if_req = 1'b0;
      @(negedge clk);
      check("t6_rst", {arvalid, awvalid, wvalid, rready, bready, if_done, mem_done,
                       resp_err, stallreq_for_cache}, 0);
      check("t6_rst_rdata", if_rdata, 0);
      rst = 1'b0; r_wait = 0;
      @(negedge clk);
      if_addr = 32'h8000_0040; rdata = 64'hCAFE_F00D_0000_0007; if_req = 1'b1;
      wait_done(n);
      check("t6_lat", n, 3);
      check("t6_done", {if_done, mem_done}, 2'b10);
      check("t6_rdata", if_rdata, 64'hCAFE_F00D_0000_0007);
      if_req = 1'b0;
      @(negedge clk);

      // --- 7: illegal read+write together, write wins
      mem_addr = 32'h0000_0010; mem_wreq = 1'b1; mem_rreq = 1'b1;
      @(negedge clk);
      check("t7_write_wins", {awvalid, wvalid, arvalid}, 3'b110);
      wait_done(n);
      check("t7_lat", n, 2);
      check("t7_done", mem_done, 1);
      mem_wreq = 1'b0; mem_rreq = 1'b0;
      repeat (2) @(negedge clk);

      check("never_both_done", both_done, 0);
      check("final_stable", stable_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
